// File: rtl/uart_pkg.sv
// Shared UART receive types and constants: FSM encoding, memory-map addresses, baud divider.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Addresses the control unit decodes to select the UART load path and the LED register.
    localparam logic [31:0] UART_MEM_ADDR = 32'h0000_1000;
    localparam logic [31:0] LEDS_MEM_ADDR = 32'h0000_1004;

    function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head; push-to-visible latency 1 clk.
// A push is accepted when not full or when a pop frees a slot in the same cycle; pop when empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_int.sv
// 8N1 UART receiver feeding a byte FIFO, with interrupt pulse and sticky error flags for the CPU.
// Byte lands ~9.5 bit times after the start edge; a byte arriving with the FIFO full is dropped (overrun).
module uart_rx_int
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        uart_read_end,
    input  logic        err_clr,
    output logic [31:0] rd_data,
    output logic        rx_valid,
    output logic        int_sig,
    output logic        overrun,
    output logic        frame_err
);
    localparam int             DIV    = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int             TCW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TCW-1:0] TC_MAX = TCW'(DIV - 1);
    localparam logic [3:0]     SC_MID = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     SC_END = 4'(OVERSAMPLE - 1);

    logic           sync1_q, sync2_q, rx_s;
    rx_state_t      state_q, state_d;
    logic [TCW-1:0] tc_q, tc_d;
    logic [3:0]     sc_q, sc_d;
    logic [2:0]     bc_q, bc_d;
    logic [7:0]     shift_q, shift_d;
    logic           int_sig_q, overrun_q, frame_err_q;
    logic           tick, push, fe_evt;
    logic           fifo_full, fifo_empty, pop_ok, push_ok, ovr_evt;
    logic [7:0]     fifo_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end
    assign rx_s = sync2_q;

    assign tick = (tc_q == TC_MAX);

    always_comb begin
        state_d = state_q;
        tc_d    = tick ? '0 : tc_q + TCW'(1);
        sc_d    = tick ? sc_q + 4'd1 : sc_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                tc_d = '0;
                sc_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Mid-bit recheck rejects line glitches shorter than half a bit.
                if (tick && sc_q == SC_MID) begin
                    sc_d    = '0;
                    bc_d    = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && sc_q == SC_END) begin
                    sc_d    = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bc_d    = bc_q + 3'd1;
                    if (bc_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && sc_q == SC_END) begin
                    state_d = IDLE;
                    push    = rx_s;
                    fe_evt  = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tc_q    <= '0;
            sc_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            sc_q    <= sc_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
        end
    end

    assign pop_ok  = uart_read_end && !fifo_empty;
    assign push_ok = push && (!fifo_full || pop_ok);
    assign ovr_evt = push && !push_ok;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (shift_q),
        .pop_i      (uart_read_end),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

    // Error events take priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_sig_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            int_sig_q   <= push_ok;
            overrun_q   <= ovr_evt || (overrun_q && !err_clr);
            frame_err_q <= fe_evt || (frame_err_q && !err_clr);
        end
    end

    assign rd_data   = fifo_empty ? 32'b0 : {24'b0, fifo_head};
    assign rx_valid  = !fifo_empty;
    assign int_sig   = int_sig_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
